inst_rom_loader: RTL and testbench
==================================

Name: inst_rom_loader

Overview:
- Instruction memory that sits directly upstream of the CPU and drives its `inst` input from the CPU's `pc` output.
- Filled at boot from a byte stream using a valid/ready handshake.
- Holds the CPU in reset while loading and releases it once the last word is written.
- Makes the system programmable without resynthesis.

Parameters:
- AW, 15, address width of the instruction store; depth = 2**AW words of 16 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, RUN or ERR.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle.
- pc  input  15  fetch address from the CPU.
- inst  output  16  instruction at `pc`, to the CPU.
- cpu_reset  output  1  active-high reset to the CPU's `reset` input.
- done  output  1  program loaded, CPU running.
- err  output  1  length header exceeded capacity.
- word_count  output  16  number of words in the loaded program.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, byte_ready=0, cpu_reset=1, done=0, err=0, word_count=0.
  - Internal write address=0, byte latch=0.
  - Memory contents are not reset.
- Handshake: a byte transfers on a rising clk edge where byte_valid=1 and byte_ready=1. byte_in is ignored otherwise.
  - byte_ready=1 exactly in states LEN_HI, LEN_LO, DATA_HI and DATA_LO (registered, from state).
- Stream format, all big-endian:
  - 2-byte length N (number of words).
  - Then N words, each sent as high byte then low byte.
- State transitions:
  - IDLE: start -> LEN_HI.
  - LEN_HI: on transfer, latch the high byte of N -> LEN_LO.
  - LEN_LO: on transfer, form N:
    - N=0 -> RUN; word_count=0; no writes.
    - N>2**AW -> ERR.
    - otherwise -> DATA_HI, write address=0.
  - DATA_HI: on transfer, latch the high byte -> DATA_LO.
  - DATA_LO: on transfer, write {hi, byte_in} to mem[write address] at that edge and increment the address.
    - If the incremented address equals N -> RUN, word_count=N.
    - Otherwise -> DATA_HI.
  - RUN: start -> LEN_HI (reload). The new word_count is set only when that load completes.
  - ERR: err=1. start -> LEN_HI and clears err at that edge.
- cpu_reset: registered, 1 in every state except RUN. It goes 0 on the edge that enters RUN and 1 on the edge that leaves RUN.
- done: registered, equal to (state==RUN).
- Fetch, combinational read:
  - inst = mem[pc] when state==RUN and pc < word_count.
  - inst = 16'h0000 otherwise, including addresses beyond the program and all non-RUN states.
  - 0x0000 is the Hack instruction `@0`, which is harmless.
- Width rules:
  - Compare pc zero-extended to 16 bits against word_count.
  - The write address is AW+1 bits so N=2**AW terminates correctly without wrap.
- start is ignored in LEN_HI, LEN_LO, DATA_HI and DATA_LO. A load cannot be aborted except by reset.
- Reset mid-load: immediate return to IDLE. Partially written words remain in memory but are unreadable because word_count=0.
- byte_valid may stay high across states. Each accepted byte advances exactly one state step; there are no bubbles required between bytes.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release; keep byte_valid=1 with no start -> byte_ready=0, cpu_reset=1, inst=0x0000 for pc=0, done=0.
- Basic load: start; stream 00 03 | 00 02 | EC 10 | 00 00 -> 3 words written, done=1 and cpu_reset=0 on the edge after the last byte, word_count=3. Then pc=0 -> 0x0002, pc=1 -> 0xEC10, pc=2 -> 0x0000, pc=3 -> 0x0000 (past the end).
- Back-pressure and gaps: same program with byte_valid toggling 1,0,0,1 and byte_in changing while valid=0 -> identical memory contents; no byte consumed while byte_valid=0.
- Zero and overflow:
  - With AW=4, length 00 00 -> RUN immediately, word_count=0.
  - With AW=4, length 00 11 (17 words) -> err=1, cpu_reset=1, byte_ready=0.
  - A subsequent start clears err.
- Reload and reset: after a load of 2 words, start in RUN -> cpu_reset=1 on the next edge and inst=0.
  - Load 1 word 0xAAAA -> word_count=1, pc=0 reads 0xAAAA.
  - Assert reset after the first data byte of a further load -> IDLE, word_count=0, err=0.
  - Also check that a start pulse during DATA_HI is ignored.

Source files
------------

// File: rtl/inst_rom_loader.sv
// ============================================================================
// Module      : inst_rom_loader
// Description : Instruction store for the CPU. It is filled at boot from a
//               length-prefixed byte stream and holds the CPU in reset
//               until the load completes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_rom_loader #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    input  logic [AW-1:0] pc,
    output logic [15:0]   inst,
    output logic          cpu_reset,
    output logic          done,
    output logic          err,
    output logic [15:0]   word_count
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LEN_HI  = 3'd1;
    localparam logic [2:0] c_LEN_LO  = 3'd2;
    localparam logic [2:0] c_DATA_HI = 3'd3;
    localparam logic [2:0] c_DATA_LO = 3'd4;
    localparam logic [2:0] c_RUN     = 3'd5;
    localparam logic [2:0] c_ERR     = 3'd6;

    localparam logic [16:0] c_CAPACITY = 17'd1 << AW;

    logic [2:0]    r_state;
    logic [2:0]    w_nextState;
    logic          r_byteReady;
    logic          r_cpuReset;
    logic          r_done;
    logic          r_err;
    logic [7:0]    r_hiByte;
    logic [15:0]   r_len;
    logic [AW:0]   r_writeAddr;
    logic [AW:0]   w_addrNext;
    logic [15:0]   r_wordCount;
    logic [15:0]   w_lenIn;
    logic          w_xfer;
    logic          w_lastWord;
    logic          w_memWrite;

    logic [15:0]   r_mem [0:(1<<AW)-1];

    assign w_xfer     = byte_valid & r_byteReady;
    assign w_lenIn    = {r_hiByte, byte_in};
    assign w_addrNext = r_writeAddr + 1'b1;
    // Widened so a full-capacity program (N = 2**AW) matches without wrap
    assign w_lastWord = (17'(w_addrNext) == {1'b0, r_len});
    assign w_memWrite = w_xfer && (r_state == c_DATA_LO);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:    if (start) w_nextState = c_LEN_HI;
            c_LEN_HI:  if (w_xfer) w_nextState = c_LEN_LO;
            c_LEN_LO: begin
                if (w_xfer) begin
                    if (w_lenIn == 16'd0)
                        w_nextState = c_RUN;
                    else if ({1'b0, w_lenIn} > c_CAPACITY)
                        w_nextState = c_ERR;
                    else
                        w_nextState = c_DATA_HI;
                end
            end
            c_DATA_HI: if (w_xfer) w_nextState = c_DATA_LO;
            c_DATA_LO: if (w_xfer) w_nextState = w_lastWord ? c_RUN : c_DATA_HI;
            c_RUN:     if (start) w_nextState = c_LEN_HI;
            c_ERR:     if (start) w_nextState = c_LEN_HI;
            default:   w_nextState = c_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they change on
    // the same edge as the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_byteReady <= 1'b0;
            r_cpuReset  <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_byteReady <= (w_nextState == c_LEN_HI) || (w_nextState == c_LEN_LO) ||
                           (w_nextState == c_DATA_HI) || (w_nextState == c_DATA_LO);
            r_cpuReset  <= (w_nextState != c_RUN);
            r_done      <= (w_nextState == c_RUN);
            r_err       <= (w_nextState == c_ERR);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hiByte    <= 8'd0;
            r_len       <= 16'd0;
            r_writeAddr <= '0;
            r_wordCount <= 16'd0;
        end else if (w_xfer) begin
            case (r_state)
                c_LEN_HI, c_DATA_HI: r_hiByte <= byte_in;
                c_LEN_LO: begin
                    r_len       <= w_lenIn;
                    r_writeAddr <= '0;
                    if (w_lenIn == 16'd0)
                        r_wordCount <= 16'd0;
                end
                c_DATA_LO: begin
                    r_writeAddr <= w_addrNext;
                    if (w_lastWord)
                        r_wordCount <= r_len;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_memWrite)
            r_mem[r_writeAddr[AW-1:0]] <= {r_hiByte, byte_in};
    end

    // Unloaded addresses and every non-RUN state fetch 0x0000 (@0, harmless)
    assign inst = ((r_state == c_RUN) && (16'(pc) < r_wordCount)) ? r_mem[pc] : 16'h0000;

    assign byte_ready = r_byteReady;
    assign cpu_reset  = r_cpuReset;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_wordCount;

endmodule

`default_nettype wire

// File: tb/tb_inst_rom_loader.sv
// ============================================================================
// Module      : tb_inst_rom_loader
// Description : Self-checking bench for inst_rom_loader (AW=4) against a
//               program-image reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_rom_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset;
    logic          start;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic [AW-1:0] pc;
    logic [15:0]   inst;
    logic          cpu_reset;
    logic          done;
    logic          err;
    logic [15:0]   word_count;

    int checks = 0;
    int errors = 0;

    // Reference model: the program image last loaded successfully
    logic [15:0] expWords [DEPTH];
    int          expWc   = 0;
    bit          running = 0;

    inst_rom_loader #(.AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .pc(pc), .inst(inst),
        .cpu_reset(cpu_reset), .done(done), .err(err), .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b, input int gapMax);
        int gap = (gapMax > 0) ? int'($urandom_range(gapMax)) : 0;
        int wait_cnt = 0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        while (!byte_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (!byte_ready) begin
            errors++;
            $display("FAIL send_byte timeout: byte_ready=%b required 1", byte_ready);
            return;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_header(input int n, input int gapMax);
        logic [15:0] len = 16'(n);
        send_byte(len[15:8], gapMax);
        send_byte(len[7:0], gapMax);
    endtask

    // Streams the header and expWords[0..n-1], then checks completion status
    task automatic load_program(input int n, input int gapMax);
        pulse_start();
        send_header(n, gapMax);
        for (int i = 0; i < n; i++) begin
            send_byte(expWords[i][15:8], gapMax);
            send_byte(expWords[i][7:0], gapMax);
        end
        expWc   = n;
        running = 1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL load_done: got %b want 1", done); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL load_cpu_reset: got %b want 0", cpu_reset); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL load_byte_ready: got %b want 0", byte_ready); end
        checks++; if (word_count !== 16'(n)) begin errors++; $display("FAIL load_word_count: got %0d want %0d", word_count, n); end
    endtask

    task automatic check_contents(input string tag);
        logic [15:0] exp;
        for (int p = 0; p < DEPTH; p++) begin
            @(negedge clk);
            pc = AW'(p);
            #1;
            exp = (running && p < expWc) ? expWords[p] : 16'h0000;
            checks++;
            if (inst !== exp) begin
                errors++;
                $display("FAIL %s inst pc=%0d: got %h want %h", tag, p, inst, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; byte_valid = 1'b1; byte_in = 8'h5A; pc = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready: got %b want 0", byte_ready); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
        checks++; if (inst !== 16'h0000) begin errors++; $display("FAIL reset_inst: got %h want 0000", inst); end
    endtask

    task automatic test_basic_load();
        expWords[0] = 16'h0002; expWords[1] = 16'hEC10; expWords[2] = 16'h0000;
        load_program(3, 0);
        check_contents("basic");
    endtask

    task automatic test_backpressure();
        expWords[0] = 16'h1234; expWords[1] = 16'hEC10; expWords[2] = 16'hBEEF;
        load_program(3, 2);
        check_contents("backpressure");
    endtask

    task automatic test_zero_overflow();
        pulse_start();
        send_header(0, 0);
        running = 1; expWc = 0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
        checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL zero_word_count: got %0d want 0", word_count); end
        check_contents("zero");

        pulse_start();
        send_header(DEPTH + 1, 0);
        running = 0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", err); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL ovf_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL ovf_byte_ready: got %b want 0", byte_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ovf_done: got %b want 0", done); end

        pulse_start();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_clear_err: got %b want 0", err); end
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL ovf_restart_ready: got %b want 1", byte_ready); end
        // Full-capacity program on the restarted load
        send_header(DEPTH, 1);
        for (int i = 0; i < DEPTH; i++) begin
            expWords[i] = 16'($urandom);
            send_byte(expWords[i][15:8], 1);
            send_byte(expWords[i][7:0], 1);
        end
        running = 1; expWc = DEPTH;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %b want 1", done); end
        checks++; if (word_count !== 16'(DEPTH)) begin errors++; $display("FAIL full_word_count: got %0d want %0d", word_count, DEPTH); end
        check_contents("full");
    endtask

    task automatic test_reload_reset();
        expWords[0] = 16'h0F0F; expWords[1] = 16'h7777;
        load_program(2, 0);
        pulse_start();
        running = 0;
        @(negedge clk); pc = '0; #1;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reload_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reload_done: got %b want 0", done); end
        checks++; if (word_count !== 16'd2) begin errors++; $display("FAIL reload_word_count_hold: got %0d want 2", word_count); end
        checks++; if (inst !== 16'h0000) begin errors++; $display("FAIL reload_inst: got %h want 0000", inst); end
        send_header(1, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hAA, 0);
        expWords[0] = 16'hAAAA; expWc = 1; running = 1;
        checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL reload_word_count: got %0d want 1", word_count); end
        check_contents("reload");

        // Start during DATA_HI must not disturb the load
        expWords[0] = 16'h1357; expWords[1] = 16'h2468;
        pulse_start();
        send_header(2, 0);
        send_byte(8'h13, 0);
        send_byte(8'h57, 0);
        pulse_start();
        send_byte(8'h24, 0);
        send_byte(8'h68, 0);
        expWc = 2; running = 1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL start_ignored_done: got %b want 1", done); end
        check_contents("start_ignored");

        pulse_start();
        send_header(2, 0);
        send_byte(8'h99, 0);
        #2 reset = 1'b0;
        running = 0; expWc = 0;
        #1;
        checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL midreset_word_count: got %0d want 0", word_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL midreset_err: got %b want 0", err); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL midreset_byte_ready: got %b want 0", byte_ready); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL midreset_cpu_reset: got %b want 1", cpu_reset); end
        @(negedge clk);
        reset = 1'b1;
        check_contents("midreset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int n = int'($urandom_range(DEPTH, 1));
            for (int i = 0; i < n; i++) expWords[i] = 16'($urandom);
            load_program(n, 3);
            check_contents("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_backpressure();
        test_zero_overflow();
        test_reload_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
